// File: rtl/snake_vga_render_if.sv
// Game-state inputs and VGA outputs of the snake renderer.
// master: the renderer (reads game state, drives the display).
// slave: the game core / display side.
interface snake_vga_render_if #(
  parameter int c_GRID_IDX_SZ = 10,
  parameter int c_WIDTH       = 32,
  parameter int c_HEIGHT      = 32
);
  logic [(c_WIDTH+1)*(c_HEIGHT+1)-1:0] i_SnakeGrid;
  logic [c_GRID_IDX_SZ-1:0]            i_Food;
  logic                                i_Kill;
  logic                                o_HSync;
  logic                                o_VSync;
  logic [3:0]                          o_Red;
  logic [3:0]                          o_Green;
  logic [3:0]                          o_Blue;
  logic                                o_Blank;
  logic                                o_FrameTick;

  modport master (
    input  i_SnakeGrid, i_Food, i_Kill,
    output o_HSync, o_VSync, o_Red, o_Green, o_Blue, o_Blank, o_FrameTick
  );

  modport slave (
    output i_SnakeGrid, i_Food, i_Kill,
    input  o_HSync, o_VSync, o_Red, o_Green, o_Blue, o_Blank, o_FrameTick
  );
endinterface

// File: rtl/snake_vga_render.sv
// 640x480@60 VGA renderer for the snake game. Stage 0 holds the raster and
// cell counters, stage 1 holds decoded timing and cell coordinates, stage 2
// looks the cell up in a once-per-frame shadow of the game state and drives
// the outputs, giving a fixed 2-cycle latency on every output.
module snake_vga_render #(
  parameter int c_GRID_IDX_SZ = 10,
  parameter int c_WIDTH       = 32,
  parameter int c_HEIGHT      = 32,
  parameter int c_CELL_PX     = 15
) (
  input logic                i_Clk,
  input logic                i_Rst,
  snake_vga_render_if.master bus
);
  localparam int c_GRID_BITS = (c_WIDTH + 1) * (c_HEIGHT + 1);
  localparam int c_CELLS     = c_WIDTH * c_HEIGHT;
  localparam int c_IDX_W     = $clog2(c_GRID_BITS);
  localparam int c_PLAY_W    = c_WIDTH * c_CELL_PX;

  localparam logic [9:0] c_H_LAST    = 10'd799;
  localparam logic [9:0] c_V_LAST    = 10'd524;
  localparam logic [9:0] c_H_ACT     = 10'd640;
  localparam logic [9:0] c_H_SYNC0   = 10'd656;
  localparam logic [9:0] c_H_SYNC1   = 10'd752;
  localparam logic [9:0] c_V_ACT     = 10'd480;
  localparam logic [9:0] c_V_SYNC0   = 10'd490;
  localparam logic [9:0] c_V_SYNC1   = 10'd492;
  localparam logic [9:0] c_X0        = 10'((640 - c_PLAY_W) / 2);
  localparam logic [9:0] c_X1        = 10'((640 - c_PLAY_W) / 2 + c_PLAY_W);
  localparam logic [9:0] c_CELL_LAST = 10'(c_CELL_PX - 1);
  localparam logic [9:0] c_COL_LAST  = 10'(c_WIDTH - 1);
  localparam logic [9:0] c_ROW_LAST  = 10'(c_HEIGHT - 1);

  // Stage 0: raster position plus cell sub-counters
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] col_q, col_d, col_px_q, col_px_d;
  logic [9:0] srow_q, srow_d, row_px_q, row_px_d;
  logic       capture;

  // Stage 1: decoded timing and cell coordinates
  logic       hsync_q, vsync_q, blank_q, play_q, tick_q;
  logic [9:0] cell_col_q, cell_row_q;

  // Shadow copy of the game state
  logic [c_GRID_BITS-1:0]   grid_q;
  logic [c_GRID_IDX_SZ-1:0] food_q;
  logic                     kill_q;
  logic                     valid_q;

  // Stage 2 lookup
  logic [c_IDX_W-1:0] idx;
  logic               snake_hit, food_hit, border;
  logic [11:0]        rgb;

  // Next raster position; cell counters restart at the play-area edge and at frame start
  always_comb begin
    h_d = (h_q == c_H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == c_H_LAST) begin
      v_d = (v_q == c_V_LAST) ? 10'd0 : v_q + 10'd1;
    end

    col_d    = col_q;
    col_px_d = col_px_q + 10'd1;
    if (h_d == c_X0) begin
      col_d    = 10'd0;
      col_px_d = 10'd0;
    end else if (col_px_q == c_CELL_LAST) begin
      col_px_d = 10'd0;
      col_d    = col_q + 10'd1;
    end

    srow_d   = srow_q;
    row_px_d = row_px_q;
    if (h_q == c_H_LAST) begin
      if (v_d == 10'd0) begin
        srow_d   = 10'd0;
        row_px_d = 10'd0;
      end else if (row_px_q == c_CELL_LAST) begin
        row_px_d = 10'd0;
        srow_d   = srow_q + 10'd1;
      end else begin
        row_px_d = row_px_q + 10'd1;
      end
    end

    capture = (h_q == 10'd0) && (v_q == c_V_ACT);
  end

  // Raster counters
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      h_q      <= '0;
      v_q      <= '0;
      col_q    <= '0;
      col_px_q <= '0;
      srow_q   <= '0;
      row_px_q <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      col_q    <= col_d;
      col_px_q <= col_px_d;
      srow_q   <= srow_d;
      row_px_q <= row_px_d;
    end
  end

  // Shadow capture at the first blanked line; valid_q hides the zeroed state after reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      grid_q  <= '0;
      food_q  <= '0;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (capture) begin
      grid_q  <= bus.i_SnakeGrid;
      food_q  <= bus.i_Food;
      kill_q  <= bus.i_Kill;
      valid_q <= 1'b1;
    end
  end

  // Stage 1: sync/blank decode and screen-row to grid-row flip
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      blank_q    <= 1'b1;
      play_q     <= 1'b0;
      tick_q     <= 1'b0;
      cell_col_q <= '0;
      cell_row_q <= '0;
    end else begin
      hsync_q    <= !((h_q >= c_H_SYNC0) && (h_q < c_H_SYNC1));
      vsync_q    <= !((v_q >= c_V_SYNC0) && (v_q < c_V_SYNC1));
      blank_q    <= !((h_q < c_H_ACT) && (v_q < c_V_ACT));
      play_q     <= (h_q >= c_X0) && (h_q < c_X1) && (v_q < c_V_ACT);
      tick_q     <= capture;
      cell_col_q <= col_q;
      cell_row_q <= c_ROW_LAST - srow_q;
    end
  end

  // Stage 2: cell lookup and colour priority
  always_comb begin
    idx       = c_IDX_W'({10'd0, cell_row_q} * 20'(c_WIDTH) + {10'd0, cell_col_q});
    snake_hit = (int'(idx) < c_CELLS) && grid_q[idx];
    food_hit  = (int'(food_q) == int'(idx)) && (int'(food_q) < c_CELLS);
    border    = (cell_row_q == 10'd0) || (cell_row_q == c_ROW_LAST) ||
                (cell_col_q == 10'd0) || (cell_col_q == c_COL_LAST);
    rgb = 12'h000;
    if (play_q) begin
      if (valid_q && snake_hit) begin
        rgb = kill_q ? 12'hFF0 : 12'h0F0;
      end else if (valid_q && food_hit) begin
        rgb = 12'hF00;
      end else if (border) begin
        rgb = 12'h888;
      end
    end
  end

  // Output registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bus.o_HSync     <= 1'b1;
      bus.o_VSync     <= 1'b1;
      bus.o_Blank     <= 1'b1;
      bus.o_FrameTick <= 1'b0;
      bus.o_Red       <= 4'h0;
      bus.o_Green     <= 4'h0;
      bus.o_Blue      <= 4'h0;
    end else begin
      bus.o_HSync     <= hsync_q;
      bus.o_VSync     <= vsync_q;
      bus.o_Blank     <= blank_q;
      bus.o_FrameTick <= tick_q;
      bus.o_Red       <= blank_q ? 4'h0 : rgb[11:8];
      bus.o_Green     <= blank_q ? 4'h0 : rgb[7:4];
      bus.o_Blue      <= blank_q ? 4'h0 : rgb[3:0];
    end
  end
endmodule

// File: tb/tb_snake_vga_render.sv
// Bench for snake_vga_render: random game states, a pixel-level reference
// model computed from raster arithmetic, and a check on every output cycle.
`timescale 1ns/1ps
module tb_snake_vga_render;
  localparam int Frame = 420000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   k;
  int   epoch;
  bit   mon_en;

  // Reference model state
  logic [1088:0] m_grid;
  logic [9:0]    m_food;
  logic          m_kill;
  logic          m_valid;

  int hs_lows, vs_lows, ticks, first_fall;

  snake_vga_render_if bus ();

  snake_vga_render dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(64'd25_000_000);
    $display("FAIL watchdog k=%0d", k);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  function automatic logic [15:0] out_vec();
    return {bus.o_HSync, bus.o_VSync, bus.o_Blank, bus.o_FrameTick,
            bus.o_Red, bus.o_Green, bus.o_Blue};
  endfunction

  // Output cycle index (since release) of pixel (x, y) in frame f
  function automatic int pk(input int x, input int y, input int f);
    return f * Frame + y * 800 + x + 2;
  endfunction

  // Expected {hsync, vsync, blank, tick, rgb} for output cycle kk
  function automatic logic [15:0] model_px(input int kk);
    int p, x, y, col, srow, idx;
    logic hs, vs, bl, tk;
    logic [11:0] c;
    if (kk < 2) return 16'hE000;
    p  = (kk - 2) % Frame;
    x  = p % 800;
    y  = p / 800;
    tk = (x == 0) && (y == 480);
    hs = !(x >= 656 && x < 752);
    vs = !(y == 490 || y == 491);
    bl = !(x < 640 && y < 480);
    c  = 12'h000;
    if (!bl && x >= 80 && x < 560) begin
      col  = (x - 80) / 15;
      srow = y / 15;
      idx  = (31 - srow) * 32 + col;
      if (m_valid && m_grid[idx]) c = m_kill ? 12'hFF0 : 12'h0F0;
      else if (m_valid && int'(m_food) == idx) c = 12'hF00;
      else if (srow == 0 || srow == 31 || col == 0 || col == 31) c = 12'h888;
    end
    return {hs, vs, bl, tk, c};
  endfunction

  task automatic fill_grid();
    for (int i = 0; i < 1089; i++) bus.i_SnakeGrid[i] = ($urandom_range(3, 0) == 0);
  endtask

  task automatic wait_k(input int target);
    while (k < target) @(posedge clk);
  endtask

  // Per-cycle monitor
  always @(negedge clk) begin
    logic [15:0] got;
    if (mon_en) begin
      got = out_vec();
      check_eq("pix", {16'd0, got}, {16'd0, model_px(k)});

      if (epoch == 1 && k >= 2 && k < Frame + 2) begin
        if (!got[15]) hs_lows++;
        if (!got[14]) vs_lows++;
        if (got[12]) ticks++;
        if (first_fall < 0 && !got[15]) first_fall = k;
      end
      if (epoch == 1 && k == Frame + 2) begin
        check_eq("hs_lows", hs_lows, 96 * 525);
        check_eq("vs_lows", vs_lows, 1600);
        check_eq("ticks", ticks, 1);
        check_eq("hs_fall", first_fall, 658);
      end

      if (epoch == 1 && k == pk(320, 225, 1)) check_eq("snake528", got[11:0], 12'h0F0);
      if (epoch == 1 && k == pk(95, 450, 1)) check_eq("food33", got[11:0], 12'hF00);
      if (epoch == 1 && k == pk(80, 300, 1)) check_eq("border_l", got[11:0], 12'h888);
      if (epoch == 1 && k == pk(10, 300, 1)) check_eq("outside", got[12:0], 13'h0);
      if (epoch == 2 && k == pk(320, 225, 0)) check_eq("hidden", got[11:0], 12'h000);
      if (epoch == 2 && k == pk(95, 450, 1)) check_eq("kill33", got[11:0], 12'hFF0);

      if (k % Frame == 480 * 800) begin
        m_grid  = bus.i_SnakeGrid;
        m_food  = bus.i_Food;
        m_kill  = bus.i_Kill;
        m_valid = 1'b1;
      end
      k++;
    end
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    k          = 0;
    epoch      = 0;
    mon_en     = 1'b0;
    hs_lows    = 0;
    vs_lows    = 0;
    ticks      = 0;
    first_fall = -1;
    m_grid     = '0;
    m_food     = '0;
    m_kill     = 1'b0;
    m_valid    = 1'b0;

    // State A: random grid with cell 528 set, food on cell 33
    fill_grid();
    bus.i_SnakeGrid[528] = 1'b1;
    bus.i_SnakeGrid[33]  = 1'b0;
    bus.i_Food           = 10'd33;
    bus.i_Kill           = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_out", {16'd0, out_vec()}, 32'hE000);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    epoch = 1;
    mon_en = 1'b1;

    // State B arrives at v=100 of the frame showing A
    wait_k(Frame + 100 * 800);
    #1;
    fill_grid();
    bus.i_SnakeGrid[528] = 1'b1;
    bus.i_SnakeGrid[33]  = 1'b1;
    bus.i_Food           = 10'd33;
    bus.i_Kill           = 1'b1;

    // Mid-frame reset at v=300
    wait_k(Frame + 300 * 800);
    #1 rst = 1'b1;
    mon_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("midrst", {16'd0, out_vec()}, 32'hE000);
    end
    m_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    epoch = 2;
    mon_en = 1'b1;

    // State C arrives at v=100 of the frame showing B
    wait_k(Frame + 100 * 800);
    #1;
    fill_grid();
    bus.i_Food = 10'($urandom_range(1023, 0));
    bus.i_Kill = 1'b0;

    wait_k(Frame + 480 * 800);
    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_vga_render.md
# snake_vga_render

Reads the game state produced by the snake game core (flattened snake bitmap, food index, kill flag) and draws it on a 640x480@60 VGA display. It generates sync timing, maps each visible pixel to a grid cell and outputs 12-bit colour. It also supplies a once-per-frame tick that the top level uses to advance the game. It captures a shadow copy of the game state once per frame so the picture never tears.

## Interface
- c_GRID_IDX_SZ, 10: width of the grid index / food location.
- c_WIDTH, 32: grid columns.
- c_HEIGHT, 32: grid rows.
- c_CELL_PX, 15: cell edge in pixels; c_HEIGHT*c_CELL_PX must be 480 and c_WIDTH*c_CELL_PX must be ≤ 640.
- i_Clk  in  1  pixel clock, 25.175 MHz nominal, one pixel per cycle.
- i_Rst  in  1  reset i_Rst, synchronous, active-high.
- i_SnakeGrid  in  (c_WIDTH+1)*(c_HEIGHT+1)  snake bitmap, index = row*c_WIDTH + col, row 0 is the bottom of the grid; bits ≥ c_WIDTH*c_HEIGHT are ignored.
- i_Food  in  c_GRID_IDX_SZ  food cell index, same encoding.
- i_Kill  in  1  game-over flag.
- o_HSync  out  1  horizontal sync, active-low.
- o_VSync  out  1  vertical sync, active-low.
- o_Red, o_Green, o_Blue  out  4 each  pixel colour; 0 whenever blanked.
- o_Blank  out  1  1 outside the 640x480 active area.
- o_FrameTick  out  1  one-cycle pulse at each shadow capture.

## Operation
- Horizontal counter h runs 0..799 and wraps to 0. Vertical counter v increments when h wraps, runs 0..524 and wraps to 0.
- Horizontal timing: active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical timing: active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Snapshot: at h=0, v=480, register i_SnakeGrid, i_Food and i_Kill into shadow registers and pulse o_FrameTick. All drawing uses only the shadow copy.
- Play area: x0 = (640 - c_WIDTH*c_CELL_PX)/2, which is 80 by default. The play area spans x0 ≤ x < x0 + c_WIDTH*c_CELL_PX and 0 ≤ y < 480.
- Cell column and row are tracked with incrementing sub-counters (pixel-in-cell, cell index). No divider is used.
- Screen cell row s (0 at the top) maps to grid row c_HEIGHT-1-s.
- Border cells are those in row 0, row c_HEIGHT-1, column 0 or column c_WIDTH-1.
- Colour priority, highest first:
  - snake bit set: 0x0F0, or 0xFF0 if shadow kill = 1;
  - food cell: 0xF00;
  - border cell: 0x888;
  - any other cell in the play area: 0x000;
  - outside the play area: 0x000.
- If the food index is ≥ c_WIDTH*c_HEIGHT, no food is drawn.

## Timing
- Reset values: h = 0, v = 0, all shadow registers 0, o_HSync = 1, o_VSync = 1, o_Red/o_Green/o_Blue = 0, o_Blank = 1, o_FrameTick = 0. Reset overrides all other activity in the same cycle.
- Pipeline latency: the outputs for counter position (h, v) appear exactly 2 cycles after the counters hold (h, v). o_HSync, o_VSync, o_Blank and colour are delayed equally, so relative alignment is exact.
- o_FrameTick is asserted on the output 2 cycles after counter (0, 480), and stays high for exactly one cycle per 420000 cycles.
- A grid change that arrives between captures has no visible effect until the frame that follows the next capture.
- Reset mid-frame:
  - outputs are back at their reset values on the cycle after i_Rst is sampled high;
  - a new frame starts at (0, 0) after release;
  - the first capture happens 480*800 cycles after release;
  - until then the display shows background and borders only.
- If i_Rst is high on the capture cycle, no capture and no tick occur.

## Test plan
- Reset values and periods: assert i_Rst, release, run 2 frames. Required: all outputs at reset values during reset; o_HSync low for 96 of every 800 cycles; o_VSync low for 1600 of every 420000 cycles; first o_HSync fall 658 cycles after release.
- Single snake cell: grid bit 528 (row 16, column 16) set, capture taken. Required: colour 0x0F0 exactly at y 225-239, x 320-334, with 0x000 in the neighbouring interior cells.
- Food and border: food = 33 (row 1, column 1), empty grid. Required: colour 0xF00 at y 450-464, x 95-109; 0x888 at x 80-94 for every visible row; x 0-79 and x 560-639 blank-coloured 0x000 with o_Blank = 0.
- Priority and kill: snake bit and food on cell 33, i_Kill = 1. Required: that cell drawn 0xFF0, not 0xF00.
- No tearing: change i_SnakeGrid at v = 100. Required: rows 100-479 of the current frame unchanged; the change is visible only in the frame after the next o_FrameTick.
- Mid-frame reset: assert i_Rst at v = 300 with a snake on screen. Required: outputs at reset values next cycle; next frame all-background apart from borders; the snake reappears after the first o_FrameTick.
